// File: rtl/exe_stage_mul.sv
// exe_stage_mul: execute stage with MEM/WB forwarding, single-cycle ALU and
// an iterative shift-add multiplier that stalls the front end while it runs.
package exe_stage_mul_pkg;
   typedef enum logic [3:0] {
      CMD_NOP, CMD_ADD, CMD_SUB, CMD_AND, CMD_OR, CMD_XOR, CMD_SLL, CMD_SRL, CMD_MUL
   } execmd_t;
endpackage

module exe_stage_mul
   import exe_stage_mul_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int SH_W   = $clog2(DATA_W)
) (
   input  logic              clk,
   input  logic              rstn,
   input  execmd_t           exe_cmd,
   input  logic [DATA_W-1:0] val1,
   input  logic [DATA_W-1:0] val2,
   input  logic [DATA_W-1:0] st_value,
   input  logic [DATA_W-1:0] pc,
   input  logic [ADDR_W-1:0] dest,
   input  logic [ADDR_W-1:0] src1,
   input  logic [ADDR_W-1:0] src2,
   input  logic              mem_r_en,
   input  logic              mem_w_en,
   input  logic              wb_en,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] mem_fwd_dest,
   input  logic              mem_fwd_wb,
   input  logic [DATA_W-1:0] mem_fwd_val,
   input  logic [ADDR_W-1:0] wb_fwd_dest,
   input  logic              wb_fwd_wb,
   input  logic [DATA_W-1:0] wb_fwd_val,
   output logic              stall,
   output logic [DATA_W-1:0] alu_res_o,
   output logic [DATA_W-1:0] st_value_o,
   output logic [DATA_W-1:0] pc_o,
   output logic [ADDR_W-1:0] dest_o,
   output logic              mem_r_en_o,
   output logic              mem_w_en_o,
   output logic              wb_en_o,
   output logic              br_taken_o
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state_q, state_d;
   logic [SH_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
   logic [DATA_W-1:0] op_a, op_b, st_fwd, alu, res;
   logic [DATA_W-1:0] res_q, st_q, pc_q;
   logic [ADDR_W-1:0] dest_q;
   logic              r_q, w_q, wb_q, br_q, bubble;
   logic              m1, w1, m2, w2;

   // register 0 is never forwarded; the MEM stage holds the newer value
   assign m1     = mem_fwd_wb && mem_fwd_dest == src1 && src1 != '0;
   assign w1     = wb_fwd_wb && wb_fwd_dest == src1 && src1 != '0;
   assign m2     = mem_fwd_wb && mem_fwd_dest == src2 && src2 != '0;
   assign w2     = wb_fwd_wb && wb_fwd_dest == src2 && src2 != '0;
   assign op_a   = m1 ? mem_fwd_val : w1 ? wb_fwd_val : val1;
   assign op_b   = m2 ? mem_fwd_val : w2 ? wb_fwd_val : val2;
   assign st_fwd = m2 ? mem_fwd_val : w2 ? wb_fwd_val : st_value;

   always_comb begin
      alu = '0;
      case (exe_cmd)
         CMD_ADD: alu = op_a + op_b;
         CMD_SUB: alu = op_a - op_b;
         CMD_AND: alu = op_a & op_b;
         CMD_OR:  alu = op_a | op_b;
         CMD_XOR: alu = op_a ^ op_b;
         CMD_SLL: alu = op_a << op_b[SH_W-1:0];
         CMD_SRL: alu = op_a >> op_b[SH_W-1:0];
         default: alu = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      res     = alu;
      bubble  = 1'b0;
      stall   = 1'b0;
      case (state_q)
         IDLE: if (exe_cmd == CMD_MUL) begin
            stall   = 1'b1;
            bubble  = 1'b1;
            a_d     = op_a;
            b_d     = op_b;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = BUSY;
         end
         BUSY: begin
            stall   = 1'b1;
            bubble  = 1'b1;
            acc_d   = acc_q + (b_q[cnt_q] ? (a_q << cnt_q) : '0);
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == SH_W'(DATA_W-1)) ? DONE : BUSY;
         end
         DONE: begin
            res     = acc_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         res_q   <= '0;
         st_q    <= '0;
         pc_q    <= '0;
         dest_q  <= '0;
         r_q     <= 1'b0;
         w_q     <= 1'b0;
         wb_q    <= 1'b0;
         br_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         res_q   <= bubble ? '0 : res;
         st_q    <= bubble ? '0 : st_fwd;
         pc_q    <= bubble ? '0 : pc;
         dest_q  <= bubble ? '0 : dest;
         r_q     <= !bubble && mem_r_en;
         w_q     <= !bubble && mem_w_en;
         wb_q    <= !bubble && wb_en;
         br_q    <= !bubble && br_taken;
      end
   end

   assign alu_res_o  = res_q;
   assign st_value_o = st_q;
   assign pc_o       = pc_q;
   assign dest_o     = dest_q;
   assign mem_r_en_o = r_q;
   assign mem_w_en_o = w_q;
   assign wb_en_o    = wb_q;
   assign br_taken_o = br_q;
endmodule
